shot_scheduler: RTL and testbench

Manages a shared pool of projectile slots for the tank-vs-monsters game. It arbitrates fire requests between the player tank and the monsters, advancing every live projectile once per game tick. It retires projectiles that leave the play field and drives per-pixel "projectile here" flags for the RGB mux in the block controller. It runs on the same slow game clock as the tank and monster position registers.

---
 rtl/shot_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_shot_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shot_scheduler.sv
// shot_scheduler: shared projectile slot pool for the tank and the monsters.
// Arbitrates fire requests (tank first, monsters round-robin with one slot
// held back for the tank), advances live projectiles once per game tick,
// retires them at the play-field edges and flags projectile pixels for VGA.
module shot_scheduler #(
    parameter int NUM_MONS = 5,
    parameter int SLOTS    = 4,
    parameter int SPEED    = 4,
    parameter int Y_MIN    = 35,
    parameter int Y_MAX    = 515
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fire,
    input  logic [9:0]               tank_x,
    input  logic [9:0]               tank_y,
    input  logic [NUM_MONS-1:0]      mons_req,
    input  logic [10*NUM_MONS-1:0]   mons_x,
    input  logic [10*NUM_MONS-1:0]   mons_y,
    input  logic [9:0]               hCount,
    input  logic [9:0]               vCount,
    output logic                     tank_grant,
    output logic [NUM_MONS-1:0]      mons_grant,
    output logic [2:0]               free_cnt,
    output logic                     shot_pix,
    output logic                     bomb_pix
);

    localparam int RW = (NUM_MONS > 1) ? $clog2(NUM_MONS) : 1;

    // Slot state and arbitration registers
    logic                r_fire_q;
    logic [RW-1:0]       r_rr;
    logic [SLOTS-1:0]    r_live;
    logic [SLOTS-1:0]    r_mons_own;
    logic [9:0]          r_x [SLOTS];
    logic [9:0]          r_y [SLOTS];
    logic                r_tank_grant;
    logic [NUM_MONS-1:0] r_mons_grant;
    logic [2:0]          r_free_cnt;

    // Arbitration results
    logic                w_tank_rise;
    logic                w_tank_live;
    logic                w_tank_go;
    logic [NUM_MONS-1:0] w_req_rot;
    logic                w_found;
    logic [RW:0]         w_sum;
    logic [RW-1:0]       w_win;
    logic                w_mons_go;
    logic [NUM_MONS-1:0] w_mons_oh;
    logic [RW-1:0]       w_rr_n;
    logic [9:0]          w_sx;
    logic [9:0]          w_sy;
    logic [SLOTS-1:0]    w_alloc_oh;
    logic                w_free_found;

    // Next slot state
    logic [SLOTS-1:0]    w_live_n;
    logic [SLOTS-1:0]    w_own_n;
    logic [9:0]          w_x_n [SLOTS];
    logic [9:0]          w_y_n [SLOTS];
    logic [2:0]          w_cnt_n;

    // Arbitration: tank priority, monster round-robin, lowest free slot
    always_comb begin
        w_tank_rise = fire & ~r_fire_q;
        w_tank_live = |(r_live & ~r_mons_own);
        w_tank_go   = w_tank_rise && !w_tank_live && (r_free_cnt >= 3'd1);

        // rotate requests so that bit 0 corresponds to monster r_rr
        w_req_rot = '0;
        for (int unsigned k = 0; k < NUM_MONS; k++) begin
            for (int unsigned j = 0; j < NUM_MONS; j++) begin
                if (r_rr == RW'(j))
                    w_req_rot[k] = mons_req[(j + k) % NUM_MONS];
            end
        end

        w_found = 1'b0;
        w_sum   = '0;
        w_win   = '0;
        for (int unsigned k = 0; k < NUM_MONS; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr} + (RW+1)'(k);
                if (w_sum >= (RW+1)'(NUM_MONS))
                    w_sum = w_sum - (RW+1)'(NUM_MONS);
                w_win   = w_sum[RW-1:0];
            end
        end

        w_mons_go = !w_tank_go && w_found && (r_free_cnt >= 3'd2);

        w_mons_oh = '0;
        w_sx      = tank_x;
        w_sy      = tank_y;
        for (int unsigned i = 0; i < NUM_MONS; i++) begin
            if (w_mons_go && (w_win == RW'(i))) begin
                w_mons_oh[i] = 1'b1;
                w_sx         = mons_x[10*i +: 10];
                w_sy         = mons_y[10*i +: 10] + 10'd4;
            end
        end

        w_rr_n = r_rr;
        if (w_mons_go)
            w_rr_n = (w_win == RW'(NUM_MONS - 1)) ? '0 : w_win + RW'(1);

        w_alloc_oh   = '0;
        w_free_found = 1'b0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (!w_free_found && !r_live[s]) begin
                w_free_found = 1'b1;
                w_alloc_oh[s] = w_tank_go || w_mons_go;
            end
        end
    end

    // Spawn, move and retire each slot; count the resulting free slots
    always_comb begin
        w_live_n = r_live;
        w_own_n  = r_mons_own;
        w_x_n    = r_x;
        w_y_n    = r_y;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (w_alloc_oh[s]) begin
                w_live_n[s] = 1'b1;
                w_own_n[s]  = w_mons_go;
                w_x_n[s]    = w_sx;
                w_y_n[s]    = w_sy;
            end else if (r_live[s]) begin
                if (!r_mons_own[s]) begin
                    if ({1'b0, r_y[s]} < 11'(Y_MIN + SPEED))
                        w_live_n[s] = 1'b0;
                    else
                        w_y_n[s] = r_y[s] - 10'(SPEED);
                end else begin
                    if ({1'b0, r_y[s]} + 11'(SPEED) > 11'(Y_MAX))
                        w_live_n[s] = 1'b0;
                    else
                        w_y_n[s] = r_y[s] + 10'(SPEED);
                end
            end
        end

        w_cnt_n = '0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (!w_live_n[s])
                w_cnt_n = w_cnt_n + 3'd1;
        end
    end

    // State register; fire_q keeps tracking fire through reset
    always_ff @(posedge clk) begin
        r_fire_q <= fire;
        if (rst) begin
            r_rr         <= '0;
            r_live       <= '0;
            r_mons_own   <= '0;
            r_tank_grant <= 1'b0;
            r_mons_grant <= '0;
            r_free_cnt   <= 3'(SLOTS);
            for (int unsigned s = 0; s < SLOTS; s++) begin
                r_x[s] <= '0;
                r_y[s] <= '0;
            end
        end else begin
            r_rr         <= w_rr_n;
            r_live       <= w_live_n;
            r_mons_own   <= w_own_n;
            r_tank_grant <= w_tank_go;
            r_mons_grant <= w_mons_oh;
            r_free_cnt   <= w_cnt_n;
            r_x          <= w_x_n;
            r_y          <= w_y_n;
        end
    end

    // Pixel hit test against every live slot, split by owner
    always_comb begin
        shot_pix = 1'b0;
        bomb_pix = 1'b0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (r_live[s]
                && ({1'b0, hCount} + 11'd1 >= {1'b0, r_x[s]})
                && ({1'b0, hCount} <= {1'b0, r_x[s]} + 11'd1)
                && ({1'b0, vCount} + 11'd3 >= {1'b0, r_y[s]})
                && ({1'b0, vCount} <= {1'b0, r_y[s]} + 11'd3)) begin
                if (r_mons_own[s])
                    bomb_pix = 1'b1;
                else
                    shot_pix = 1'b1;
            end
        end
    end

    assign tank_grant = r_tank_grant;
    assign mons_grant = r_mons_grant;
    assign free_cnt   = r_free_cnt;

endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler: per-cycle expected grants/free count go
// through a scoreboard queue; pixel flags are checked directly.
module tb_shot_scheduler;

    logic        clk;
    logic        rst;
    logic        fire;
    logic [9:0]  tank_x;
    logic [9:0]  tank_y;
    logic [4:0]  mons_req;
    logic [49:0] mons_x;
    logic [49:0] mons_y;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        tank_grant;
    logic [4:0]  mons_grant;
    logic [2:0]  free_cnt;
    logic        shot_pix;
    logic        bomb_pix;

    shot_scheduler #(
        .NUM_MONS(5),
        .SLOTS(4),
        .SPEED(4),
        .Y_MIN(35),
        .Y_MAX(515)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fire(fire),
        .tank_x(tank_x),
        .tank_y(tank_y),
        .mons_req(mons_req),
        .mons_x(mons_x),
        .mons_y(mons_y),
        .hCount(hCount),
        .vCount(vCount),
        .tank_grant(tank_grant),
        .mons_grant(mons_grant),
        .free_cnt(free_cnt),
        .shot_pix(shot_pix),
        .bomb_pix(bomb_pix)
    );

    typedef struct packed {
        logic       tg;
        logic [4:0] mg;
        logic [2:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $error("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // push expectation for the coming edge, then pop and compare after it
    task automatic tick(input string tag, input logic tg, input logic [4:0] mg, input logic [2:0] fc);
        exp_t e;
        e.tg = tg;
        e.mg = mg;
        e.fc = fc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".tank_grant"}, 32'(tank_grant), 32'(e.tg));
        chk({tag, ".mons_grant"}, 32'(mons_grant), 32'(e.mg));
        chk({tag, ".free_cnt"},   32'(free_cnt),   32'(e.fc));
    endtask

    task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic es, input logic eb);
        hCount = h;
        vCount = v;
        #1;
        chk({tag, ".shot_pix"}, 32'(shot_pix), 32'(es));
        chk({tag, ".bomb_pix"}, 32'(bomb_pix), 32'(eb));
    endtask

    initial begin
        rst      = 1'b1;
        fire     = 1'b0;
        tank_x   = 10'd450;
        tank_y   = 10'd400;
        mons_req = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            mons_x[10*i +: 10] = 10'(100 + 50 * i);
            mons_y[10*i +: 10] = 10'd100;
        end
        hCount = '0;
        vCount = '0;

        // reset
        tick("rst0", 1'b0, 5'b00000, 3'd4);
        tick("rst1", 1'b0, 5'b00000, 3'd4);
        pix("rst_pixA", 10'd450, 10'd400, 1'b0, 1'b0);
        pix("rst_pixB", 10'd0,   10'd0,   1'b0, 1'b0);
        rst = 1'b0;

        // tank shot, fire held 10 cycles
        fire = 1'b1;
        tick("shot_grant", 1'b1, 5'b00000, 3'd3);
        pix("shot_at",    10'd450, 10'd400, 1'b1, 1'b0);
        pix("shot_edge",  10'd451, 10'd403, 1'b1, 1'b0);
        pix("shot_out",   10'd452, 10'd400, 1'b0, 1'b0);
        tick("shot_move", 1'b0, 5'b00000, 3'd3);
        pix("shot_moved", 10'd450, 10'd396, 1'b1, 1'b0);
        pix("shot_old",   10'd450, 10'd400, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            tick("shot_hold", 1'b0, 5'b00000, 3'd3);

        // clear pool
        fire = 1'b0;
        rst  = 1'b1;
        tick("rst2", 1'b0, 5'b00000, 3'd4);
        rst  = 1'b0;

        // retirement at the top line
        tank_y = 10'd40;
        fire   = 1'b1;
        tick("ret_grant", 1'b1, 5'b00000, 3'd3);
        fire   = 1'b0;
        tick("ret_y36", 1'b0, 5'b00000, 3'd3);
        pix("ret_live", 10'd450, 10'd36, 1'b1, 1'b0);
        tick("ret_free", 1'b0, 5'b00000, 3'd4);
        pix("ret_gone", 10'd450, 10'd36, 1'b0, 1'b0);
        pix("ret_gone2", 10'd450, 10'd32, 1'b0, 1'b0);

        // round-robin and tank reserve
        mons_req = 5'b11111;
        tick("rr0", 1'b0, 5'b00001, 3'd3);
        tick("rr1", 1'b0, 5'b00010, 3'd2);
        tick("rr2", 1'b0, 5'b00100, 3'd1);
        tick("rr_reserve", 1'b0, 5'b00000, 3'd1);
        pix("bomb_m0", 10'd100, 10'd116, 1'b0, 1'b1);
        pix("bomb_m1", 10'd150, 10'd112, 1'b0, 1'b1);
        fire = 1'b1;
        tick("rr_tank", 1'b1, 5'b00000, 3'd0);
        tick("rr_full", 1'b0, 5'b00000, 3'd0);

        // priority: tank wins, monster retried, rr_ptr lands on 3
        fire     = 1'b0;
        mons_req = 5'b00000;
        rst      = 1'b1;
        tick("rst3", 1'b0, 5'b00000, 3'd4);
        rst      = 1'b0;
        tank_y   = 10'd400;
        fire     = 1'b1;
        mons_req = 5'b00100;
        tick("pri_tank", 1'b1, 5'b00000, 3'd3);
        tick("pri_mons", 1'b0, 5'b00100, 3'd2);
        mons_req = 5'b01100;
        tick("pri_rr3", 1'b0, 5'b01000, 3'd1);
        mons_req = 5'b00000;
        pix("mid_shot", 10'd450, 10'd392, 1'b1, 1'b0);
        pix("mid_bomb", 10'd200, 10'd108, 1'b0, 1'b1);

        // reset mid-flight with fire held
        rst = 1'b1;
        tick("mid_rst", 1'b0, 5'b00000, 3'd4);
        pix("mid_rst_shot", 10'd450, 10'd392, 1'b0, 1'b0);
        pix("mid_rst_bomb", 10'd200, 10'd108, 1'b0, 1'b0);
        rst = 1'b0;
        tick("mid_hold0", 1'b0, 5'b00000, 3'd4);
        tick("mid_hold1", 1'b0, 5'b00000, 3'd4);
        fire = 1'b0;
        tick("mid_low", 1'b0, 5'b00000, 3'd4);
        fire = 1'b1;
        tick("mid_rise", 1'b1, 5'b00000, 3'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
